// File: rtl/vga_pkg.sv
// Shared VGA constants: RGB565 colours, default visible area and the
// bitmap-ROM address width helper.
package vga_pkg;

    localparam int H_VALID_DEF = 640;
    localparam int V_VALID_DEF = 480;

    localparam logic [15:0] BLACK  = 16'h0000;
    localparam logic [15:0] WHITE  = 16'hFFFF;
    localparam logic [15:0] GOLDEN = 16'hFEC0;

    function automatic int rom_addr_w(input int bmp_w, input int bmp_h);
        return $clog2((bmp_w / 16) * bmp_h);
    endfunction

endpackage

// File: rtl/vga_bounce_axis.sv
// One axis of the bouncing origin: steps pos by STEP once per frame tick,
// clamps at 0 and LIMIT, and reverses direction on reaching either end.
module vga_bounce_axis #(
    parameter int LIMIT = 384,
    parameter int STEP  = 2,
    parameter int INIT  = 192
) (
    input  logic       vga_clk,
    input  logic       sys_rst,
    input  logic       tick,
    input  logic       move_en,
    output logic [9:0] pos,
    output logic       dir
);

    localparam logic [10:0] LIMIT_W = 11'(LIMIT);
    localparam logic [10:0] STEP_W  = 11'(STEP);

    function automatic logic [10:0] sat_up(input logic [10:0] p);
        logic [10:0] s;
        s = p + STEP_W;
        return (s >= LIMIT_W) ? LIMIT_W : s;
    endfunction

    function automatic logic [10:0] sat_down(input logic [10:0] p);
        return (p <= STEP_W) ? 11'd0 : p - STEP_W;
    endfunction

    logic [10:0] pos_nxt;
    logic        at_end;

    always_comb begin
        pos_nxt = dir ? sat_up({1'b0, pos}) : sat_down({1'b0, pos});
        at_end  = dir ? (pos_nxt == LIMIT_W) : (pos_nxt == 11'd0);
    end

    always_ff @(posedge vga_clk or posedge sys_rst) begin
        if (sys_rst) begin
            pos <= 10'(INIT);
            dir <= 1'b1;
        end else if (tick && move_en) begin
            pos <= pos_nxt[9:0];
            if (at_end)
                dir <= ~dir;
        end
    end

endmodule

// File: rtl/vga_char_bounce.sv
// Draws a 1-bpp bitmap that bounces around the visible area; two-stage
// pipeline from pixel coordinates to registered RGB565 pixel colour.
module vga_char_bounce
    import vga_pkg::*;
#(
    parameter int H_VALID = H_VALID_DEF,
    parameter int V_VALID = V_VALID_DEF,
    parameter int BMP_W   = 256,
    parameter int BMP_H   = 128,
    parameter int STEP    = 2
) (
    input  logic                                  vga_clk,
    input  logic                                  sys_rst,
    input  logic [9:0]                            pix_x,
    input  logic [9:0]                            pix_y,
    input  logic                                  move_en,
    input  logic [15:0]                           fg_color,
    input  logic [15:0]                           bg_color,
    output logic [rom_addr_w(BMP_W, BMP_H)-1:0]   rom_addr,
    input  logic [15:0]                           rom_data,
    output logic [15:0]                           pix_data
);

    localparam int ADDR_W = rom_addr_w(BMP_W, BMP_H);
    localparam int WPL    = BMP_W / 16;

    logic [9:0] pos_x, pos_y;
    logic       dir_x, dir_y;
    logic       frame_tick;

    assign frame_tick = (pix_x == 10'(H_VALID - 1)) && (pix_y == 10'(V_VALID - 1));

    vga_bounce_axis #(
        .LIMIT (H_VALID - BMP_W),
        .STEP  (STEP),
        .INIT  ((H_VALID - BMP_W) / 2)
    ) u_axis_x (
        .vga_clk (vga_clk),
        .sys_rst (sys_rst),
        .tick    (frame_tick),
        .move_en (move_en),
        .pos     (pos_x),
        .dir     (dir_x)
    );

    vga_bounce_axis #(
        .LIMIT (V_VALID - BMP_H),
        .STEP  (STEP),
        .INIT  ((V_VALID - BMP_H) / 2)
    ) u_axis_y (
        .vga_clk (vga_clk),
        .sys_rst (sys_rst),
        .tick    (frame_tick),
        .move_en (move_en),
        .pos     (pos_y),
        .dir     (dir_y)
    );

    // Stage 0: hit test against the bitmap window and ROM word address
    logic [9:0] ox_p0, oy_p0;
    logic       inside_p0, vld_p0;

    always_comb begin
        ox_p0     = pix_x - pos_x;
        oy_p0     = pix_y - pos_y;
        inside_p0 = (pix_x >= pos_x) && ({1'b0, pix_x} < ({1'b0, pos_x} + 11'(BMP_W))) &&
                    (pix_y >= pos_y) && ({1'b0, pix_y} < ({1'b0, pos_y} + 11'(BMP_H)));
        vld_p0    = (int'(pix_x) < H_VALID) && (int'(pix_y) < V_VALID);
        rom_addr  = '0;
        if (inside_p0)
            rom_addr = ADDR_W'(int'(oy_p0) * WPL + int'(ox_p0[9:4]));
    end

    logic       inside_p1, vld_p1;
    logic [3:0] ox_lo_p1;

    always_ff @(posedge vga_clk or posedge sys_rst) begin
        if (sys_rst) begin
            inside_p1 <= 1'b0;
            vld_p1    <= 1'b0;
            ox_lo_p1  <= 4'd0;
        end else begin
            inside_p1 <= inside_p0;
            vld_p1    <= vld_p0;
            ox_lo_p1  <= ox_p0[3:0];
        end
    end

    // Stage 1: pick colour from the ROM bit arriving this cycle
    always_ff @(posedge vga_clk or posedge sys_rst) begin
        if (sys_rst)
            pix_data <= BLACK;
        else if (!vld_p1)
            pix_data <= BLACK;
        else if (inside_p1 && rom_data[4'd15 - ox_lo_p1])
            pix_data <= fg_color;
        else
            pix_data <= bg_color;
    end

endmodule

// File: tb/tb_vga_char_bounce.sv
// Directed bench for vga_char_bounce: pixel pipeline, ROM addressing and
// frame-tick bouncing, with hand-computed expectations.
module tb_vga_char_bounce;

    logic        vga_clk = 1'b0;
    logic        sys_rst;
    logic        move_en;
    logic [9:0]  pix_x, pix_y, pix_y2;
    logic [15:0] fg_color, bg_color;
    logic [15:0] rom_data, rom_data2, rom_pat;
    logic [15:0] pix_data, pix_data2;
    logic [10:0] rom_addr, rom_addr2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 vga_clk = ~vga_clk;

    vga_char_bounce dut (
        .vga_clk  (vga_clk),
        .sys_rst  (sys_rst),
        .pix_x    (pix_x),
        .pix_y    (pix_y),
        .move_en  (move_en),
        .fg_color (fg_color),
        .bg_color (bg_color),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .pix_data (pix_data)
    );

    // Odd vertical size so a STEP=2 bounce passes through pos_y = 1.
    vga_char_bounce #(.V_VALID(481)) dut2 (
        .vga_clk  (vga_clk),
        .sys_rst  (sys_rst),
        .pix_x    (pix_x),
        .pix_y    (pix_y2),
        .move_en  (move_en),
        .fg_color (fg_color),
        .bg_color (bg_color),
        .rom_addr (rom_addr2),
        .rom_data (rom_data2),
        .pix_data (pix_data2)
    );

    always @(posedge vga_clk) begin
        rom_data  <= rom_pat;
        rom_data2 <= 16'h0000;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic show_pixel(input logic [9:0] x, input logic [9:0] y);
        @(negedge vga_clk);
        pix_x = x;
        pix_y = y;
        @(posedge vga_clk);
        @(negedge vga_clk);
        pix_x = 10'd700;
        pix_y = 10'd0;
        @(posedge vga_clk);
        #1;
    endtask

    task automatic frame_tick();
        @(negedge vga_clk);
        pix_x = 10'd639;
        pix_y = 10'd479;
        @(posedge vga_clk);
        #1;
        pix_x = 10'd700;
        pix_y = 10'd0;
    endtask

    task automatic frame_tick2();
        @(negedge vga_clk);
        pix_x  = 10'd639;
        pix_y  = 10'd480;
        pix_y2 = 10'd480;
        @(posedge vga_clk);
        #1;
        pix_x  = 10'd700;
        pix_y  = 10'd0;
        pix_y2 = 10'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        sys_rst  = 1'b1;
        move_en  = 1'b0;
        pix_x    = 10'd700;
        pix_y    = 10'd0;
        pix_y2   = 10'd0;
        fg_color = 16'hFFBA;
        bg_color = 16'h001F;
        rom_pat  = 16'hFFFF;

        repeat (3) @(posedge vga_clk);
        #1;
        check("rst_pix", pix_data, 16'h0000);
        check("rst_pos_x", dut.pos_x, 10'd192);
        check("rst_pos_y", dut.pos_y, 10'd176);
        check("rst_dir_x", dut.dir_x, 1'b1);
        check("rst_dir_y", dut.dir_y, 1'b1);
        @(negedge vga_clk);
        sys_rst = 1'b0;

        // ROM address: ox=128, oy=64 -> 64*16 + 8
        @(negedge vga_clk);
        pix_x = 10'd320;
        pix_y = 10'd240;
        #1;
        check("addr_center", rom_addr, 11'd1032);
        pix_x = 10'd100;
        pix_y = 10'd100;
        #1;
        check("addr_outside", rom_addr, 11'd0);
        pix_x = 10'd447;
        pix_y = 10'd303;
        #1;
        check("addr_corner", rom_addr, 11'd2047);

        show_pixel(10'd320, 10'd240);
        check("pix_center_fg", pix_data, 16'hFFBA);
        show_pixel(10'd100, 10'd100);
        check("pix_outside_bg", pix_data, 16'h001F);
        show_pixel(10'd700, 10'd240);
        check("pix_hblank", pix_data, 16'h0000);
        show_pixel(10'd320, 10'd500);
        check("pix_vblank", pix_data, 16'h0000);
        show_pixel(10'd191, 10'd176);
        check("pix_left_edge_out", pix_data, 16'h001F);
        show_pixel(10'd192, 10'd175);
        check("pix_top_edge_out", pix_data, 16'h001F);

        rom_pat = 16'h8000;
        show_pixel(10'd192, 10'd176);
        check("bit_msb_fg", pix_data, 16'hFFBA);
        show_pixel(10'd193, 10'd176);
        check("bit1_bg", pix_data, 16'h001F);
        show_pixel(10'd447, 10'd303);
        check("bit_lsb_clear", pix_data, 16'h001F);
        rom_pat = 16'h0001;
        show_pixel(10'd447, 10'd303);
        check("bit_lsb_fg", pix_data, 16'hFFBA);
        show_pixel(10'd448, 10'd303);
        check("right_edge_out", pix_data, 16'h001F);
        rom_pat = 16'hFFFF;

        fg_color = 16'hFFFF;
        show_pixel(10'd320, 10'd240);
        check("fg_change", pix_data, 16'hFFFF);
        fg_color = 16'hFFBA;

        frame_tick();
        check("frozen_pos_x", dut.pos_x, 10'd192);
        check("frozen_pos_y", dut.pos_y, 10'd176);

        // 96 moving ticks: x reaches 384 and turns; y turned at 352 after 88
        move_en = 1'b1;
        for (int i = 0; i < 96; i++) frame_tick();
        check("x_at_limit", dut.pos_x, 10'd384);
        check("x_dir_turn", dut.dir_x, 1'b0);
        check("y_after96", dut.pos_y, 10'd336);
        check("y_dir_after96", dut.dir_y, 1'b0);
        frame_tick();
        check("x_tick97", dut.pos_x, 10'd382);
        check("x_dir97", dut.dir_x, 1'b0);
        frame_tick();
        check("x_tick98", dut.pos_x, 10'd380);

        move_en = 1'b0;
        for (int i = 0; i < 3; i++) frame_tick();
        check("hold_pos_x", dut.pos_x, 10'd380);
        check("hold_pos_y", dut.pos_y, 10'd332);
        check("hold_dir_x", dut.dir_x, 1'b0);
        check("hold_dir_y", dut.dir_y, 1'b0);

        // Reset asserted mid-frame, mid-cycle
        move_en = 1'b1;
        @(negedge vga_clk);
        pix_x = 10'd50;
        pix_y = 10'd10;
        @(posedge vga_clk);
        @(posedge vga_clk);
        #1;
        check("pre_rst_bg", pix_data, 16'h001F);
        #2;
        sys_rst = 1'b1;
        #1;
        check("midrst_pix", pix_data, 16'h0000);
        check("midrst_pos_x", dut.pos_x, 10'd192);
        check("midrst_pos_y", dut.pos_y, 10'd176);
        check("midrst_dir_x", dut.dir_x, 1'b1);
        check("midrst_dir_y", dut.dir_y, 1'b1);
        @(negedge vga_clk);
        sys_rst = 1'b0;
        show_pixel(10'd320, 10'd240);
        check("post_rst_fg", pix_data, 16'hFFBA);
        frame_tick();
        check("resume_pos_x", dut.pos_x, 10'd194);
        check("resume_pos_y", dut.pos_y, 10'd178);

        // Lower bound on the odd-height instance: up to 353, then down to 1
        for (int i = 0; i < 265; i++) frame_tick2();
        check("y2_pos1", dut2.pos_y, 10'd1);
        check("y2_dir_down", dut2.dir_y, 1'b0);
        frame_tick2();
        check("y2_pos0", dut2.pos_y, 10'd0);
        check("y2_dir_up", dut2.dir_y, 1'b1);
        check("main_untouched", dut.pos_x, 10'd194);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_char_bounce.md
VGA_CHAR_BOUNCE -- requirements
Module: vga_char_bounce

Interface
REQ-001 Parameter H_VALID, default 640, visible pixels per line.
REQ-002 Parameter V_VALID, default 480, visible lines per frame.
REQ-003 Parameter BMP_W, default 256, bitmap width in pixels; multiple of 16.
REQ-004 Parameter BMP_H, default 128, bitmap height in lines.
REQ-005 Parameter STEP, default 2, pixels moved per frame on each axis; 1..15.
REQ-006 vga_clk, input, 1: pixel clock; the block's only clock.
REQ-007 sys_rst, input, 1: asynchronous, active-high reset.
REQ-008 pix_x, input, 10: current pixel column; values >= H_VALID mean blanking.
REQ-009 pix_y, input, 10: current pixel row; values >= V_VALID mean blanking.
REQ-010 move_en, input, 1: 1 = bitmap bounces; 0 = position frozen.
REQ-011 fg_color, input, 16: RGB565 colour for set bitmap bits.
REQ-012 bg_color, input, 16: RGB565 colour for all other visible pixels.
REQ-013 rom_addr, output, log2(BMP_W/16*BMP_H): bitmap word address.
REQ-014 rom_data, input, 16: bitmap word returned one cycle after rom_addr; the MSB is the leftmost pixel.
REQ-015 pix_data, output, 16: registered pixel colour.

Function
REQ-016 The block SHALL hold the bitmap origin in registers pos_x (10 bits) and pos_y (10 bits), and direction flags dir_x and dir_y (1 = increasing).
REQ-017 A frame tick SHALL fire for exactly one cycle when pix_x == H_VALID-1 and pix_y == V_VALID-1.
REQ-018 On a frame tick with move_en = 1, each axis SHALL update independently.
REQ-019 On that update, a coordinate moving up SHALL become min(pos + STEP, LIMIT), where LIMIT is H_VALID-BMP_W for x and V_VALID-BMP_H for y.
REQ-020 On that update, a coordinate moving down SHALL become max(pos - STEP, 0).
REQ-021 On that update, the direction flag SHALL invert when the new value equals its limit (LIMIT or 0).
REQ-022 On a frame tick with move_en = 0, pos_x, pos_y, dir_x and dir_y SHALL be unchanged.
REQ-023 The position registers SHALL change only on a frame tick, so the origin is constant for a whole frame.
REQ-024 Stage 0 SHALL compute inside = (pos_x <= pix_x < pos_x+BMP_W) and (pos_y <= pix_y < pos_y+BMP_H), plus offsets ox = pix_x-pos_x and oy = pix_y-pos_y.
REQ-025 Stage 0 SHALL drive rom_addr = oy*(BMP_W/16) + ox[..4] combinationally, and register inside, ox[3:0] and visible (pix_x < H_VALID and pix_y < V_VALID).
REQ-026 Stage 1 SHALL register pix_data as follows, in priority order.
REQ-027 If visible = 0, pix_data SHALL be 16'h0000.
REQ-028 Otherwise, if inside = 1 and rom_data[15-ox[3:0]] = 1, pix_data SHALL be fg_color.
REQ-029 In all other cases, pix_data SHALL be bg_color.
REQ-030 Latency from pix_x/pix_y to pix_data SHALL be exactly 2 cycles; upstream timing aligns to this.
REQ-031 When inside = 0, rom_addr SHALL be driven to 0 and its data ignored.
REQ-032 fg_color and bg_color SHALL be sampled in stage 1 with no extra latency; a change takes effect on the next pixel.
REQ-033 If BMP_W > H_VALID or BMP_H > V_VALID, behaviour is undefined; the bench does not exercise it.

Reset
REQ-034 While sys_rst = 1, pix_data SHALL be 0 and the pipeline registers 0.
REQ-035 While sys_rst = 1, pos_x SHALL be (H_VALID-BMP_W)/2, pos_y (V_VALID-BMP_H)/2, and dir_x = dir_y = 1.
REQ-036 Reset asserted mid-frame SHALL take effect immediately.
REQ-037 After release, motion SHALL resume at the first frame tick seen.

Structure
REQ-038 RGB565 colour constants (BLACK, WHITE, GOLDEN), H_VALID/V_VALID defaults and the rom_addr width function SHALL live in shared package vga_pkg.
REQ-039 The per-frame position/direction update SHALL be one sub-module, vga_bounce_axis, instantiated twice (x and y) with LIMIT and STEP parameters.

Verification
REQ-040 Reset, then pix_x=320, pix_y=240 with a ROM model all-ones and fg=16'hFFBA -> pix_data = 16'hFFBA two cycles later.
REQ-041 pix_x=100, pix_y=100 -> pix_data = bg_color; pix_x=700 -> pix_data = 0 two cycles later.
REQ-042 move_en=1, STEP=2, pos_x forced near the limit: at the first frame tick pos_x = 382 and dir_x = 0; at the next tick pos_x = 380.
REQ-043 pos_y=1, dir_y=0 at a frame tick -> pos_y = 0 and dir_y = 1.
REQ-044 move_en=0 across 3 frame ticks -> pos_x, pos_y and the dir flags are unchanged.
REQ-045 Assert sys_rst at pixel (50,10) mid-frame -> pix_data = 0 immediately, pos = (192,176).
REQ-046 Release sys_rst -> pix_data for pixel (320,240) = fg_color after 2 cycles.
